// File: rtl/mc_memory_bank_if.sv
// Bus bundle between the memory bank and its users: circuit load/store ports,
// host preload/dump port, mode control and debug status.
interface mc_memory_bank_if #(
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned ADDRESS_SIZE = 32
);
    logic                    load_en;
    logic [ADDRESS_SIZE-1:0] load_addr;
    logic [DATA_SIZE-1:0]    load_data;
    logic                    store_en;
    logic [ADDRESS_SIZE-1:0] store_addr;
    logic [DATA_SIZE-1:0]    store_data;
    logic                    start;
    logic                    done;
    logic                    running;
    logic                    host_valid;
    logic                    host_ready;
    logic                    host_write;
    logic [ADDRESS_SIZE-1:0] host_addr;
    logic [DATA_SIZE-1:0]    host_wdata;
    logic                    host_rvalid;
    logic                    host_rready;
    logic [DATA_SIZE-1:0]    host_rdata;
    logic [31:0]             load_count;
    logic [31:0]             store_count;
    logic                    err_oob;
    logic                    err_mode;

    modport master (
        output load_en, load_addr, store_en, store_addr, store_data,
        output start, done,
        output host_valid, host_write, host_addr, host_wdata, host_rready,
        input  load_data, running, host_ready, host_rvalid, host_rdata,
        input  load_count, store_count, err_oob, err_mode
    );

    modport slave (
        input  load_en, load_addr, store_en, store_addr, store_data,
        input  start, done,
        input  host_valid, host_write, host_addr, host_wdata, host_rready,
        output load_data, running, host_ready, host_rvalid, host_rdata,
        output load_count, store_count, err_oob, err_mode
    );
endinterface

// File: rtl/mc_memory_bank.sv
// Word-addressed memory bank with one-cycle circuit load port, store port and a
// host preload/dump port; a HOST/RUN mode machine decides who owns the array.
module mc_memory_bank #(
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned ADDRESS_SIZE = 32,
    parameter int unsigned DEPTH        = 1024
) (
    input  logic             clk,
    input  logic             rst,
    mc_memory_bank_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 32;
    localparam logic [ADDRESS_SIZE-1:0] DEPTH_A = ADDRESS_SIZE'(DEPTH);

    typedef enum logic {ST_HOST, ST_RUN} state_e;

    state_e                 state_q, state_d;
    logic                   start_pend_q, start_pend_d;
    logic [DATA_SIZE-1:0]   load_data_q, load_data_d;
    logic                   host_rvalid_q, host_rvalid_d;
    logic [DATA_SIZE-1:0]   host_rdata_q, host_rdata_d;
    logic [CNT_W-1:0]       load_count_q, load_count_d;
    logic [CNT_W-1:0]       store_count_q, store_count_d;
    logic                   err_oob_q, err_oob_d;
    logic                   err_mode_q, err_mode_d;

    logic [DATA_SIZE-1:0]   mem [DEPTH];
    logic                   mem_we_c;
    logic [IDX_W-1:0]       mem_widx_c;
    logic [DATA_SIZE-1:0]   mem_wdata_c;

    logic                   host_ready_c;
    logic                   host_acc_c;
    logic                   load_ok_c, store_ok_c, host_ok_c;

    // Range checks use the full address so aliased high addresses never hit the array.
    assign load_ok_c    = bus.load_addr  < DEPTH_A;
    assign store_ok_c   = bus.store_addr < DEPTH_A;
    assign host_ok_c    = bus.host_addr  < DEPTH_A;
    assign host_ready_c = (state_q == ST_HOST) && !host_rvalid_q;
    assign host_acc_c   = bus.host_valid && host_ready_c;

    always_comb begin
        state_d       = state_q;
        start_pend_d  = start_pend_q;
        load_data_d   = load_data_q;
        host_rvalid_d = host_rvalid_q;
        host_rdata_d  = host_rdata_q;
        load_count_d  = load_count_q;
        store_count_d = store_count_q;
        err_oob_d     = err_oob_q;
        err_mode_d    = err_mode_q;
        mem_we_c      = 1'b0;
        mem_widx_c    = '0;
        mem_wdata_c   = '0;

        if (host_rvalid_q && bus.host_rready) begin
            host_rvalid_d = 1'b0;
        end
        if ((bus.load_en && !load_ok_c) || (bus.store_en && !store_ok_c) ||
            (host_acc_c && !host_ok_c)) begin
            err_oob_d = 1'b1;
        end

        case (state_q)
            ST_HOST: begin
                if (bus.load_en || bus.store_en) begin
                    err_mode_d = 1'b1;
                end
                if (host_acc_c) begin
                    if (bus.host_write) begin
                        mem_we_c    = host_ok_c;
                        mem_widx_c  = bus.host_addr[IDX_W-1:0];
                        mem_wdata_c = bus.host_wdata;
                    end else begin
                        host_rvalid_d = 1'b1;
                        host_rdata_d  = host_ok_c ? mem[bus.host_addr[IDX_W-1:0]] : '0;
                    end
                end
                // A pending host response holds off the handover; start is remembered.
                if (bus.start || start_pend_q) begin
                    if (host_rvalid_q) begin
                        start_pend_d = 1'b1;
                    end else begin
                        state_d       = ST_RUN;
                        start_pend_d  = 1'b0;
                        load_count_d  = '0;
                        store_count_d = '0;
                        err_oob_d     = 1'b0;
                        err_mode_d    = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (bus.load_en) begin
                    load_count_d = load_count_q + CNT_W'(1);
                    if (!load_ok_c) begin
                        load_data_d = '0;
                    end else if (bus.store_en && (bus.store_addr == bus.load_addr)) begin
                        load_data_d = bus.store_data;
                    end else begin
                        load_data_d = mem[bus.load_addr[IDX_W-1:0]];
                    end
                end
                if (bus.store_en) begin
                    store_count_d = store_count_q + CNT_W'(1);
                    mem_we_c      = store_ok_c;
                    mem_widx_c    = bus.store_addr[IDX_W-1:0];
                    mem_wdata_c   = bus.store_data;
                end
                if (bus.done) begin
                    state_d = ST_HOST;
                end
            end
            default: state_d = ST_HOST;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_HOST;
            start_pend_q  <= 1'b0;
            load_data_q   <= '0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            load_count_q  <= '0;
            store_count_q <= '0;
            err_oob_q     <= 1'b0;
            err_mode_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_pend_q  <= start_pend_d;
            load_data_q   <= load_data_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
            load_count_q  <= load_count_d;
            store_count_q <= store_count_d;
            err_oob_q     <= err_oob_d;
            err_mode_q    <= err_mode_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_widx_c] <= mem_wdata_c;
        end
    end

    assign bus.running     = (state_q == ST_RUN);
    assign bus.host_ready  = host_ready_c;
    assign bus.load_data   = load_data_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.host_rdata  = host_rdata_q;
    assign bus.load_count  = load_count_q;
    assign bus.store_count = store_count_q;
    assign bus.err_oob     = err_oob_q;
    assign bus.err_mode    = err_mode_q;
endmodule

// File: tb/tb_mc_memory_bank.sv
// Directed scenario bench for mc_memory_bank: host preload, circuit run,
// forwarding, host backpressure, error flags, done boundary and async reset.
module tb_mc_memory_bank;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mc_memory_bank_if #(.DATA_SIZE(32), .ADDRESS_SIZE(32)) bus ();

    mc_memory_bank #(.DATA_SIZE(32), .ADDRESS_SIZE(32), .DEPTH(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [31:0] addr, input logic [31:0] data);
        bus.host_valid = 1'b1; bus.host_write = 1'b1;
        bus.host_addr  = addr; bus.host_wdata = data;
        tick();
        bus.host_valid = 1'b0; bus.host_write = 1'b0;
    endtask

    task automatic host_read(input logic [31:0] addr, output logic [31:0] data, output logic vld);
        bus.host_valid = 1'b1; bus.host_write = 1'b0; bus.host_addr = addr;
        tick();
        bus.host_valid = 1'b0;
        data = bus.host_rdata;
        vld  = bus.host_rvalid;
        bus.host_rready = 1'b1;
        tick();
        bus.host_rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL rst_running: got %b want 0", bus.running); end
        n_cmp++; if (bus.host_ready !== 1'b1) begin n_err++; $display("FAIL rst_host_ready: got %b want 1", bus.host_ready); end
        n_cmp++; if (bus.load_data !== 32'd0) begin n_err++; $display("FAIL rst_load_data: got %h want 0", bus.load_data); end
        n_cmp++; if (bus.host_rvalid !== 1'b0 || bus.host_rdata !== 32'd0) begin n_err++; $display("FAIL rst_host_resp: got %b/%h want 0/0", bus.host_rvalid, bus.host_rdata); end
        n_cmp++; if (bus.load_count !== 32'd0 || bus.store_count !== 32'd0) begin n_err++; $display("FAIL rst_counts: got %0d/%0d want 0/0", bus.load_count, bus.store_count); end
        n_cmp++; if (bus.err_oob !== 1'b0 || bus.err_mode !== 1'b0) begin n_err++; $display("FAIL rst_errs: got %b/%b want 0/0", bus.err_oob, bus.err_mode); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_preload_run();
        for (int i = 0; i < 8; i++) host_write(32'(i), 32'(100 + i));
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        n_cmp++; if (bus.running !== 1'b1 || bus.host_ready !== 1'b0) begin n_err++; $display("FAIL run_entry: got running=%b ready=%b want 1/0", bus.running, bus.host_ready); end
        bus.load_en = 1'b1; bus.load_addr = 32'd3; tick();
        n_cmp++; if (bus.load_data !== 32'd103) begin n_err++; $display("FAIL load3: got %0d want 103", bus.load_data); end
        bus.load_addr = 32'd7; tick(); bus.load_en = 1'b0;
        n_cmp++; if (bus.load_data !== 32'd107) begin n_err++; $display("FAIL load7: got %0d want 107", bus.load_data); end
        bus.load_addr = 32'd0; tick();
        n_cmp++; if (bus.load_data !== 32'd107) begin n_err++; $display("FAIL load_hold: got %0d want 107", bus.load_data); end
        n_cmp++; if (bus.load_count !== 32'd2) begin n_err++; $display("FAIL load_count2: got %0d want 2", bus.load_count); end
    endtask

    task automatic test_forwarding();
        bus.store_en = 1'b1; bus.store_addr = 32'd5; bus.store_data = 32'hABCD;
        bus.load_en  = 1'b1; bus.load_addr  = 32'd5;
        tick();
        bus.store_en = 1'b0;
        n_cmp++; if (bus.load_data !== 32'hABCD) begin n_err++; $display("FAIL fwd_same_cycle: got %h want abcd", bus.load_data); end
        tick();
        bus.load_en = 1'b0;
        n_cmp++; if (bus.load_data !== 32'hABCD) begin n_err++; $display("FAIL fwd_reload: got %h want abcd", bus.load_data); end
        n_cmp++; if (bus.store_count !== 32'd1 || bus.load_count !== 32'd4) begin n_err++; $display("FAIL fwd_counts: got st=%0d ld=%0d want 1/4", bus.store_count, bus.load_count); end
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL fwd_done: got running=%b want 0", bus.running); end
    endtask

    task automatic test_back_to_back();
        bus.host_valid = 1'b1; bus.host_write = 1'b0; bus.host_addr = 32'd2;
        tick();
        bus.host_valid = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== 32'd102 || bus.host_ready !== 1'b0 || bus.running !== 1'b0) begin
                n_err++; $display("FAIL bp_hold%0d: got rv=%b rd=%0d rdy=%b run=%b want 1/102/0/0", i, bus.host_rvalid, bus.host_rdata, bus.host_ready, bus.running);
            end
            tick();
        end
        bus.host_rready = 1'b1; tick(); bus.host_rready = 1'b0;
        n_cmp++; if (bus.host_rvalid !== 1'b0 || bus.running !== 1'b0) begin n_err++; $display("FAIL bp_consume: got rv=%b run=%b want 0/0", bus.host_rvalid, bus.running); end
        tick();
        n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL bp_deferred_start: got running=%b want 1", bus.running); end
        bus.done = 1'b1; tick(); bus.done = 1'b0;
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic        v;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.store_en = 1'b1; bus.store_addr = 32'd1024; bus.store_data = 32'hDEAD;
        tick();
        bus.store_en = 1'b0;
        n_cmp++; if (bus.err_oob !== 1'b1) begin n_err++; $display("FAIL oob_store_flag: got %b want 1", bus.err_oob); end
        bus.load_en = 1'b1; bus.load_addr = 32'd0; tick();
        n_cmp++; if (bus.load_data !== 32'd100) begin n_err++; $display("FAIL oob_no_alias: got %0d want 100", bus.load_data); end
        bus.load_addr = 32'd2000; tick(); bus.load_en = 1'b0;
        n_cmp++; if (bus.load_data !== 32'd0) begin n_err++; $display("FAIL oob_load_zero: got %0d want 0", bus.load_data); end
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        bus.store_en = 1'b1; bus.store_addr = 32'd4; bus.store_data = 32'h77;
        tick();
        bus.store_en = 1'b0;
        n_cmp++; if (bus.err_mode !== 1'b1 || bus.err_oob !== 1'b1) begin n_err++; $display("FAIL mode_flag: got mode=%b oob=%b want 1/1", bus.err_mode, bus.err_oob); end
        n_cmp++; if (bus.load_data !== 32'd0) begin n_err++; $display("FAIL mode_load_data: got %0d want 0", bus.load_data); end
        host_read(32'd4, d, v);
        n_cmp++; if (v !== 1'b1 || d !== 32'd104) begin n_err++; $display("FAIL mode_no_write: got v=%b d=%0d want 1/104", v, d); end
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        n_cmp++; if (bus.err_oob !== 1'b0 || bus.err_mode !== 1'b0 || bus.load_count !== 32'd0) begin n_err++; $display("FAIL err_clear: got oob=%b mode=%b lc=%0d want 0/0/0", bus.err_oob, bus.err_mode, bus.load_count); end
        bus.done = 1'b1; tick(); bus.done = 1'b0;
    endtask

    task automatic test_done_boundary();
        logic [31:0] d;
        logic        v;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.store_en = 1'b1; bus.store_addr = 32'd9; bus.store_data = 32'd55; bus.done = 1'b1;
        tick();
        bus.store_en = 1'b0; bus.done = 1'b0;
        n_cmp++; if (bus.running !== 1'b0 || bus.store_count !== 32'd1) begin n_err++; $display("FAIL done_store: got run=%b sc=%0d want 0/1", bus.running, bus.store_count); end
        host_read(32'd9, d, v);
        n_cmp++; if (v !== 1'b1 || d !== 32'd55) begin n_err++; $display("FAIL done_readback: got v=%b d=%0d want 1/55", v, d); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        logic        v;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.store_en = 1'b1; bus.store_addr = 32'd10; bus.store_data = 32'h1234;
        bus.load_en  = 1'b1; bus.load_addr  = 32'd3;
        tick();
        bus.store_en = 1'b0; bus.load_en = 1'b0;
        n_cmp++; if (bus.load_data !== 32'd103 || bus.load_count !== 32'd1) begin n_err++; $display("FAIL ar_pre: got ld=%0d lc=%0d want 103/1", bus.load_data, bus.load_count); end
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (bus.running !== 1'b0 || bus.host_ready !== 1'b1) begin n_err++; $display("FAIL ar_mode: got run=%b rdy=%b want 0/1", bus.running, bus.host_ready); end
        n_cmp++; if (bus.load_count !== 32'd0 || bus.store_count !== 32'd0 || bus.load_data !== 32'd0) begin n_err++; $display("FAIL ar_regs: got lc=%0d sc=%0d ld=%0d want 0/0/0", bus.load_count, bus.store_count, bus.load_data); end
        #2 rst = 1'b0;
        host_read(32'd10, d, v);
        n_cmp++; if (v !== 1'b1 || d !== 32'h1234) begin n_err++; $display("FAIL ar_retain10: got v=%b d=%h want 1/1234", v, d); end
        host_read(32'd3, d, v);
        n_cmp++; if (v !== 1'b1 || d !== 32'd103) begin n_err++; $display("FAIL ar_retain3: got v=%b d=%0d want 1/103", v, d); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.load_en = 1'b0; bus.load_addr = '0;
        bus.store_en = 1'b0; bus.store_addr = '0; bus.store_data = '0;
        bus.start = 1'b0; bus.done = 1'b0;
        bus.host_valid = 1'b0; bus.host_write = 1'b0; bus.host_addr = '0;
        bus.host_wdata = '0; bus.host_rready = 1'b0;
        test_reset();
        test_preload_run();
        test_forwarding();
        test_back_to_back();
        test_errors();
        test_done_boundary();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
